// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scancode receiver.
// Holds the prefix byte values and the frame FSM state encoding.
package ps2_pkg;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes the raw bus, detects ps2_clk falling edges
// and assembles start/8 data/odd parity/stop frames with a stall timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync_reg;
  logic [1:0]    data_sync_reg;
  logic          clk_prev_reg;
  frame_state_t  state_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic [CW-1:0] to_cnt_reg;
  logic          frame_err_reg;

  logic data_s;
  logic strobe;
  logic frame_good;

  assign data_s     = data_sync_reg[1];
  assign strobe     = clk_prev_reg & ~clk_sync_reg[1];
  assign frame_good = data_s & (^{shift_reg, parity_reg});

  // byte_valid is combinational so the top registers its outputs exactly one
  // clock after the stop-bit strobe.
  assign byte_valid = strobe && (state_reg == STOP) && frame_good;
  assign rx_byte    = shift_reg;
  assign frame_err  = frame_err_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
      clk_prev_reg  <= 1'b1;
      state_reg     <= IDLE;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 8'h00;
      parity_reg    <= 1'b0;
      to_cnt_reg    <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
      clk_prev_reg  <= clk_sync_reg[1];
      frame_err_reg <= 1'b0;
      if (strobe) begin
        to_cnt_reg <= '0;
        case (state_reg)
          IDLE: begin
            if (!data_s) begin
              state_reg   <= DATA;
              bit_cnt_reg <= 3'd0;
            end
          end
          DATA: begin
            shift_reg   <= {data_s, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) state_reg <= PARITY;
          end
          PARITY: begin
            parity_reg <= data_s;
            state_reg  <= STOP;
          end
          STOP: begin
            state_reg <= IDLE;
            if (!frame_good) frame_err_reg <= 1'b1;
          end
          default: state_reg <= IDLE;
        endcase
      end else if (state_reg != IDLE) begin
        if (to_cnt_reg == TO_LIMIT) begin
          state_reg     <= IDLE;
          to_cnt_reg    <= '0;
          frame_err_reg <= 1'b1;
        end else begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard scancode decoder: tracks E0/F0 prefixes and holds the code of
// the currently pressed key, pulsing code_valid on each make/break event.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] scancode,
  output logic        code_valid,
  output logic        code_break,
  output logic        frame_err
);

  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic        ext_reg;
  logic        brk_reg;
  logic [15:0] scancode_reg;
  logic        code_valid_reg;
  logic        code_break_reg;
  logic [15:0] key_next;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  assign key_next   = {ext_reg ? PREFIX_EXT : 8'h00, rx_byte};
  assign scancode   = scancode_reg;
  assign code_valid = code_valid_reg;
  assign code_break = code_break_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ext_reg        <= 1'b0;
      brk_reg        <= 1'b0;
      scancode_reg   <= 16'h0000;
      code_valid_reg <= 1'b0;
      code_break_reg <= 1'b0;
    end else begin
      code_valid_reg <= 1'b0;
      code_break_reg <= 1'b0;
      if (frame_err) begin
        ext_reg <= 1'b0;
        brk_reg <= 1'b0;
      end else if (byte_valid) begin
        if (rx_byte == PREFIX_EXT) begin
          ext_reg <= 1'b1;
        end else if (rx_byte == PREFIX_BRK) begin
          brk_reg <= 1'b1;
        end else begin
          code_valid_reg <= 1'b1;
          code_break_reg <= brk_reg;
          ext_reg        <= 1'b0;
          brk_reg        <= 1'b0;
          // A release only clears the held code if it names that same key.
          if (!brk_reg) scancode_reg <= key_next;
          else if (scancode_reg == key_next) scancode_reg <= 16'h0000;
        end
      end
    end
  end

endmodule
